// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: branch-prediction flag encoding and counter constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_types;

   // Lookup result as seen by fetch: bit 0 = BTB hit, bit 1 = hit and predicted taken.
   typedef enum logic [1:0] {
      BP_MISS   = 2'b00,
      BP_HIT_NT = 2'b01,
      BP_HIT_T  = 2'b11
   } bpred_flag_t;

   // Weakly not-taken value of a 2-bit saturating counter (2^(n-1)-1 in general).
   localparam logic [1:0] BP_CTR_WEAK_NT = 2'b01;

endpackage

// File: rtl/bp_sat_ctr_table.sv
// Pattern history table: 2^IDX_BITS saturating counters, one comb read port, one inc/dec write port.
// Latency: read is combinational; write lands on the next rising edge (same-cycle read sees old value).
// Backpressure: none; a write is accepted every cycle wr_en is high.
module bp_sat_ctr_table #(
   parameter int IDX_BITS = 8,
   parameter int CTR_BITS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IDX_BITS-1:0] rd_idx,
   output logic [CTR_BITS-1:0] rd_ctr,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_idx,
   input  logic                wr_inc
);

   localparam int                  ENTRIES  = 1 << IDX_BITS;
   // Weakly not-taken: MSB clear, all lower bits set.
   localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
   localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
   localparam logic [CTR_BITS-1:0] CTR_MIN  = {CTR_BITS{1'b0}};

   logic [CTR_BITS-1:0] ctr_q [ENTRIES];

   assign rd_ctr = ctr_q[rd_idx];

   // Counter storage: reset to weakly not-taken, then saturating increment/decrement on writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= CTR_INIT;
         end
      end else if (wr_en) begin
         if (wr_inc) begin
            if (ctr_q[wr_idx] != CTR_MAX) begin
               ctr_q[wr_idx] <= ctr_q[wr_idx] + CTR_BITS'(1);
            end
         end else if (ctr_q[wr_idx] != CTR_MIN) begin
            ctr_q[wr_idx] <= ctr_q[wr_idx] - CTR_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/branch_pred_unit.sv
// Branch predictor: direct-mapped BTB plus bimodal/gshare PHT, with speculative global history.
// Latency: lookup is combinational from fetch PC; training and history recovery land next edge.
// Backpressure: none; fetch and execute may present a lookup and an update every cycle.
module branch_pred_unit
   import rv32i_types::*;
#(
   parameter int BTB_IDX_BITS = 5,
   parameter int PHT_IDX_BITS = 8,
   parameter int HIST_BITS    = 8,
   parameter int CTR_BITS     = 2,
   parameter int MODE         = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          if_pc_in,
   input  logic                 if_valid,
   output logic [31:0]          predicted_pc,
   output logic [1:0]           btb_flag,
   output logic [HIST_BITS-1:0] pred_hist,
   input  logic                 update,
   input  logic [31:0]          ex_pc_in,
   input  logic                 ex_taken,
   input  logic [31:0]          br_out,
   input  logic [HIST_BITS-1:0] ex_hist,
   input  logic                 mispredict,
   output logic [31:0]          perf_updates,
   output logic [31:0]          perf_mispredicts
);

   localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
   localparam int TAG_BITS    = 30 - BTB_IDX_BITS;

   logic                    btb_vld_q [BTB_ENTRIES];
   logic [TAG_BITS-1:0]     btb_tag_q [BTB_ENTRIES];
   logic [31:0]             btb_tgt_q [BTB_ENTRIES];
   logic [HIST_BITS-1:0]    ghist_q;
   logic [31:0]             perf_upd_q;
   logic [31:0]             perf_mis_q;

   logic [BTB_IDX_BITS-1:0] lk_btb_idx;
   logic [BTB_IDX_BITS-1:0] ex_btb_idx;
   logic [TAG_BITS-1:0]     lk_tag;
   logic [TAG_BITS-1:0]     ex_tag;
   logic [PHT_IDX_BITS-1:0] lk_pht_idx;
   logic [PHT_IDX_BITS-1:0] ex_pht_idx;
   logic [CTR_BITS-1:0]     lk_ctr;
   logic                    lk_hit;
   logic                    lk_pred_tk;
   bpred_flag_t             lk_flag;
   logic                    unused_bits;

   assign lk_btb_idx = if_pc_in[BTB_IDX_BITS+1:2];
   assign lk_tag     = if_pc_in[31:BTB_IDX_BITS+2];
   assign ex_btb_idx = ex_pc_in[BTB_IDX_BITS+1:2];
   assign ex_tag     = ex_pc_in[31:BTB_IDX_BITS+2];

   // Byte-offset PC bits, low counter bits and the history bit that shifts out are never consumed.
   assign unused_bits = ^{ex_pc_in[1:0], lk_ctr, ex_hist[HIST_BITS-1]};

   // PHT indexing: PC word index, optionally hashed with history (zero-extended) for gshare.
   always_comb begin
      lk_pht_idx = if_pc_in[PHT_IDX_BITS+1:2];
      ex_pht_idx = ex_pc_in[PHT_IDX_BITS+1:2];
      if (MODE != 0) begin
         lk_pht_idx = lk_pht_idx ^ PHT_IDX_BITS'(ghist_q);
         ex_pht_idx = ex_pht_idx ^ PHT_IDX_BITS'(ex_hist);
      end
   end

   bp_sat_ctr_table #(
      .IDX_BITS (PHT_IDX_BITS),
      .CTR_BITS (CTR_BITS)
   ) u_pht (
      .clk    (clk),
      .rst    (rst),
      .rd_idx (lk_pht_idx),
      .rd_ctr (lk_ctr),
      .wr_en  (update),
      .wr_idx (ex_pht_idx),
      .wr_inc (ex_taken)
   );

   // Lookup: BTB hit qualifies the counter's direction; a miss or not-taken falls through to PC+4.
   always_comb begin
      lk_hit       = btb_vld_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);
      lk_pred_tk   = lk_hit && lk_ctr[CTR_BITS-1];
      lk_flag      = bpred_flag_t'({lk_pred_tk, lk_hit});
      predicted_pc = lk_pred_tk ? btb_tgt_q[lk_btb_idx] : (if_pc_in + 32'd4);
   end

   assign btb_flag         = lk_flag;
   assign pred_hist        = ghist_q;
   assign perf_updates     = perf_upd_q;
   assign perf_mispredicts = perf_mis_q;

   // BTB valid bits: cleared by reset, set when a taken branch resolves (allocate or overwrite).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_vld_q[i] <= 1'b0;
         end
      end else if (update && ex_taken) begin
         btb_vld_q[ex_btb_idx] <= 1'b1;
      end
   end

   // BTB tag/target payload: only meaningful behind a valid bit, so it needs no reset.
   always_ff @(posedge clk) begin
      if (update && ex_taken) begin
         btb_tag_q[ex_btb_idx] <= ex_tag;
         btb_tgt_q[ex_btb_idx] <= br_out;
      end
   end

   // Speculative history: a resolved mispredict rebuilds it from the snapshot, beating fetch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ghist_q <= '0;
      end else if (update && mispredict) begin
         ghist_q <= {ex_hist[HIST_BITS-2:0], ex_taken};
      end else if (if_valid && lk_hit) begin
         ghist_q <= {ghist_q[HIST_BITS-2:0], lk_pred_tk};
      end
   end

   // Performance counters: saturate at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_upd_q <= '0;
         perf_mis_q <= '0;
      end else if (update) begin
         if (perf_upd_q != 32'hFFFF_FFFF) begin
            perf_upd_q <= perf_upd_q + 32'd1;
         end
         if (mispredict && (perf_mis_q != 32'hFFFF_FFFF)) begin
            perf_mis_q <= perf_mis_q + 32'd1;
         end
      end
   end

endmodule
